// File: rtl/player_controller.sv
//==============================================================================
// Module   : player_controller
// Purpose  : Player sprite position/colour owner; steps one pixel per press,
//            honouring obstacle block flags and screen edges.
//            Define PLAYER_WRAP_EN for screen-edge wrap-around (default: clamp).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module player_controller #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int PWIDTH     = 12,
    parameter int PHEIGHT    = 12,
    parameter int H_START    = 314,
    parameter int V_START    = 234,
    parameter int SETTLE_CYC = 2,
    parameter int NUM_COLORS = 4
) (
    input  logic        btnClk,
    input  logic        rst_n,
    input  logic [3:0]  btns,
    input  logic        btnC,
    input  logic        upEnable,
    input  logic        downEnable,
    input  logic        leftEnable,
    input  logic        rightEnable,
    output logic [31:0] player_hPos,
    output logic [31:0] player_vPos,
    output logic [3:0]  player_color,
    output logic        moving,
    output logic [15:0] step_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STEP   = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    localparam logic [3:0]  c_UP    = 4'd8;
    localparam logic [3:0]  c_DOWN  = 4'd4;
    localparam logic [3:0]  c_RIGHT = 4'd2;
    localparam logic [3:0]  c_LEFT  = 4'd1;
    localparam logic [31:0] c_H_MAX = 32'(H_RES - PWIDTH);
    localparam logic [31:0] c_V_MAX = 32'(V_RES - PHEIGHT);
    localparam logic [3:0]  c_COLOR_MAX = 4'(NUM_COLORS - 1);
    localparam int          c_CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [c_CW-1:0] c_SETTLE_LOAD = c_CW'(SETTLE_CYC - 1);
`ifdef PLAYER_WRAP_EN
    localparam bit c_WRAP = 1'b1;
`else
    localparam bit c_WRAP = 1'b0;
`endif

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_dir;
    logic [c_CW-1:0]   r_settle_cnt;
    logic [31:0]       r_hpos;
    logic [31:0]       r_vpos;
    logic [31:0]       w_hpos_next;
    logic [31:0]       w_vpos_next;
    logic [3:0]        r_color;
    logic              r_btnc_q;
    logic [15:0]       r_step_count;
    logic              w_room_up;
    logic              w_room_down;
    logic              w_room_left;
    logic              w_room_right;
    logic              w_btn_ok;

    // Without wrap, a screen edge behaves exactly like an obstacle block flag.
    assign w_room_up    = c_WRAP || (r_vpos != 32'd0);
    assign w_room_down  = c_WRAP || (r_vpos <  c_V_MAX);
    assign w_room_left  = c_WRAP || (r_hpos != 32'd0);
    assign w_room_right = c_WRAP || (r_hpos <  c_H_MAX);

    always_comb begin
        w_btn_ok = 1'b0;
        case (btns)
            c_UP:    w_btn_ok = !upEnable    && w_room_up;
            c_DOWN:  w_btn_ok = !downEnable  && w_room_down;
            c_RIGHT: w_btn_ok = !rightEnable && w_room_right;
            c_LEFT:  w_btn_ok = !leftEnable  && w_room_left;
            default: w_btn_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_hpos_next = r_hpos;
        w_vpos_next = r_vpos;
        case (r_dir)
            c_UP:    w_vpos_next = (r_vpos == 32'd0)   ? c_V_MAX : r_vpos - 32'd1;
            c_DOWN:  w_vpos_next = (r_vpos >= c_V_MAX) ? 32'd0   : r_vpos + 32'd1;
            c_RIGHT: w_hpos_next = (r_hpos >= c_H_MAX) ? 32'd0   : r_hpos + 32'd1;
            c_LEFT:  w_hpos_next = (r_hpos == 32'd0)   ? c_H_MAX : r_hpos - 32'd1;
            default: ;
        endcase
    end

    always_ff @(posedge btnClk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_btn_ok) w_state_next = S_STEP;
            S_STEP:   w_state_next = S_SETTLE;
            S_SETTLE: begin
                if (r_settle_cnt == '0)
                    w_state_next = ((btns == r_dir) && w_btn_ok) ? S_STEP : S_IDLE;
            end
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge btnClk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir        <= 4'd0;
            r_settle_cnt <= '0;
            r_hpos       <= 32'(H_START);
            r_vpos       <= 32'(V_START);
            r_step_count <= 16'd0;
            r_color      <= 4'd0;
            r_btnc_q     <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_btn_ok)
                r_dir <= btns;
            if (r_state == S_STEP) begin
                r_hpos       <= w_hpos_next;
                r_vpos       <= w_vpos_next;
                r_step_count <= r_step_count + 16'd1;
                r_settle_cnt <= c_SETTLE_LOAD;
            end else if (r_state == S_SETTLE && r_settle_cnt != '0) begin
                r_settle_cnt <= r_settle_cnt - 1'b1;
            end
            r_btnc_q <= btnC;
            if (btnC && !r_btnc_q)
                r_color <= (r_color >= c_COLOR_MAX) ? 4'd0 : r_color + 4'd1;
        end
    end

    assign player_hPos  = r_hpos;
    assign player_vPos  = r_vpos;
    assign player_color = r_color;
    assign moving       = (r_state != S_IDLE);
    assign step_count   = r_step_count;

endmodule

`default_nettype wire

// File: tb/tb_player_controller.sv
//==============================================================================
// Module   : tb_player_controller
// Purpose  : Directed self-checking bench for player_controller (default build
//            clamps at edges; PLAYER_WRAP_EN selects wrap expectations).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_player_controller;

    logic        btnClk;
    logic        rst_n;
    logic [3:0]  btns;
    logic        btnC;
    logic        upEnable;
    logic        downEnable;
    logic        leftEnable;
    logic        rightEnable;
    logic [31:0] player_hPos;
    logic [31:0] player_vPos;
    logic [3:0]  player_color;
    logic        moving;
    logic [15:0] step_count;

    int tests_run = 0;
    int tests_failed = 0;

    player_controller dut (
        .btnClk       (btnClk),
        .rst_n        (rst_n),
        .btns         (btns),
        .btnC         (btnC),
        .upEnable     (upEnable),
        .downEnable   (downEnable),
        .leftEnable   (leftEnable),
        .rightEnable  (rightEnable),
        .player_hPos  (player_hPos),
        .player_vPos  (player_vPos),
        .player_color (player_color),
        .moving       (moving),
        .step_count   (step_count)
    );

    initial btnClk = 1'b0;
    always #5 btnClk = ~btnClk;

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge btnClk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected hPos after each of 9 cycles of holding right, one step per 3 cycles.
    int right_h [9] = '{314, 315, 315, 315, 316, 316, 316, 317, 317};

    initial begin
        rst_n = 1'b0; btns = 4'd0; btnC = 1'b0;
        upEnable = 1'b0; downEnable = 1'b0; leftEnable = 1'b0; rightEnable = 1'b0;
        tick(2);
        chk("rst_hpos", player_hPos, 32'd314);
        chk("rst_vpos", player_vPos, 32'd234);
        chk("rst_color", {28'd0, player_color}, 32'd0);
        chk("rst_steps", {16'd0, step_count}, 32'd0);
        chk("rst_moving", {31'd0, moving}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_moving", {31'd0, moving}, 32'd0);
            chk("idle_hpos", player_hPos, 32'd314);
        end
        chk("idle_steps", {16'd0, step_count}, 32'd0);

        // Non-one-hot request must not move.
        btns = 4'd12;
        tick(3);
        chk("nonhot_moving", {31'd0, moving}, 32'd0);
        chk("nonhot_vpos", player_vPos, 32'd234);
        btns = 4'd0;

        // Auto-repeat to the right.
        btns = 4'd2;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("right_hpos", player_hPos, 32'(right_h[i]));
            chk("right_moving", {31'd0, moving}, 32'd1);
        end
        btns = 4'd0;
        tick();
        chk("right_done_moving", {31'd0, moving}, 32'd0);
        chk("right_steps", {16'd0, step_count}, 32'd3);

        // Blocked upward request, then released.
        upEnable = 1'b1; btns = 4'd8;
        tick(5);
        chk("upblk_vpos", player_vPos, 32'd234);
        chk("upblk_moving", {31'd0, moving}, 32'd0);
        upEnable = 1'b0;
        tick();
        chk("uprel_moving", {31'd0, moving}, 32'd1);
        chk("uprel_vpos1", player_vPos, 32'd234);
        tick();
        chk("uprel_vpos2", player_vPos, 32'd233);

        // Block raised mid-SETTLE: ignored until the counter expires, then IDLE.
        upEnable = 1'b1;
        tick();
        chk("midsettle_moving", {31'd0, moving}, 32'd1);
        tick();
        chk("midsettle_idle", {31'd0, moving}, 32'd0);
        tick(4);
        chk("midsettle_vpos", player_vPos, 32'd233);
        chk("midsettle_steps", {16'd0, step_count}, 32'd4);
        upEnable = 1'b0;

        // Walk up to the top edge.
        for (int i = 0; i < 1000 && player_vPos != 32'd0; i++) tick();
        chk("reach_top", player_vPos, 32'd0);
        btns = 4'd0;
        tick(4);
        chk("top_steps", {16'd0, step_count}, 32'd237);
        chk("top_hpos", player_hPos, 32'd317);
        btns = 4'd8;
        tick();
        btns = 4'd0;
        tick(3);
`ifdef PLAYER_WRAP_EN
        chk("edge_vpos", player_vPos, 32'd468);
        chk("edge_steps", {16'd0, step_count}, 32'd238);
`else
        chk("edge_vpos", player_vPos, 32'd0);
        chk("edge_steps", {16'd0, step_count}, 32'd237);
`endif
        chk("edge_moving", {31'd0, moving}, 32'd0);

        // Colour: held press advances once, then pulses wrap 3 -> 0.
        btnC = 1'b1;
        tick();
        chk("color_first", {28'd0, player_color}, 32'd1);
        tick(5);
        chk("color_hold", {28'd0, player_color}, 32'd1);
        btnC = 1'b0;
        tick();
        for (int p = 0; p < 4; p++) begin
            btnC = 1'b1;
            tick();
            chk("color_pulse", {28'd0, player_color}, 32'((2 + p) % 4));
            btnC = 1'b0;
            tick();
        end
        btnC = 1'b1;
        tick();
        chk("color_pre_rst", {28'd0, player_color}, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("color_async_rst", {28'd0, player_color}, 32'd0);
        chk("rst2_vpos", player_vPos, 32'd234);
        btnC = 1'b0;
        tick();
        rst_n = 1'b1;

        // Reset during STEP discards the partial step.
        btns = 4'd1;
        tick();
        chk("step_moving", {31'd0, moving}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_hpos", player_hPos, 32'd314);
        chk("abort_moving", {31'd0, moving}, 32'd0);
        chk("abort_steps", {16'd0, step_count}, 32'd0);
        btns = 4'd0;
        tick();
        rst_n = 1'b1;
        tick(2);
        chk("after_abort_hpos", player_hPos, 32'd314);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
